abs_share_sched: RTL and testbench
==================================

Name: abs_share_sched

Overview:
Time-multiplexed scheduler that shares one unary sign/absolute-value engine among N bipolar bitstream requesters. Each cycle a round-robin arbiter grants one requesting channel. The granted channel's bit is processed against its own saved DEP-bit saturating counter context, and the context is written back. This lets one shared engine serve multiple independent streams without cross-channel state corruption; sits between stream generators and downstream unary accumulators.

Parameters:
N, 4, number of requester channels (>=2)
DEP, 3, width of per-channel saturating up/down counter
CW, $clog2(N), width of channel index

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req  input  N  per-channel request; bit i high = channel i presents a bit this cycle
bit_in  input  N  per-channel bipolar stream bit, sampled only for granted channel
clr  input  N  per-channel synchronous context re-init to midpoint
grant  output  N  one-hot combinational grant, same cycle as req
out_valid  output  1  registered; high one cycle after a grant
out_ch  output  CW  registered index of channel processed
out_sign  output  1  registered sign for that bit (1 = negative running value)
out_abs  output  1  registered absolute-value bit

Behaviour:
- Clock clk; reset rst_n asynchronous, active-low.
- Reset values: all contexts = midpoint M = 1<<(DEP-1); rr pointer = N-1; out_valid=0, out_ch=0, out_sign=0, out_abs=0.
- Arbitration: combinational round-robin; search starts at ptr+1 mod N and grants the first i with req[i]=1. grant is one-hot or all-zero. On any grant, ptr <= granted index; with no req, ptr holds.
- Engine, for granted channel g with context c (c taken as M if clr[g]=1 this cycle):
  - sign = ~c[DEP-1]; abs = bit_in[g] ^ sign; both use the pre-update context.
  - next c: bit=1 and c != 2^DEP-1 -> c+1; bit=0 and c != 0 -> c-1; otherwise hold (saturate at both ends, no wrap).
- Latency: one cycle. Next cycle out_valid=1, out_ch=g, out_sign/out_abs as computed. With no grant, next cycle out_valid=0 and out_ch/out_sign/out_abs hold their previous values.
- clr: for any channel i with clr[i]=1, context i <= M. If i is also granted, its bit is processed from M and the updated value (M±1) is written (update overrides plain clear). Multiple clr bits may be set together.
- Ungranted channels: context unchanged, bit_in ignored; requesters must hold req/bit until granted (no internal queue).
- Reset mid-operation: immediate return to reset values; in-flight output is discarded.
- Unsigned counter arithmetic, no overflow possible given saturation.

Test Plan:
- Reset then req=4'b1111 held: grant sequence 0001,0010,0100,1000,0001; out_ch 0,1,2,3,0 one cycle later; out_valid stays 1.
- DEP=3, only ch0 requesting, bit_in[0]=0 for 6 cycles: context 4,3,2,1,0,0; out_sign 0,1,1,1,1,1; out_abs 0,1,1,1,1,1 (saturates at 0, no wrap).
- Ch1 only, bit_in[1]=1 for 5 cycles: context 4,5,6,7,7; out_sign always 0, out_abs always 1; context stays at 7.
- Ch0 driven to 0 via zeros, then ch2 serviced with bit 1: ch2 out_sign=0 (own context 4 untouched); ch0 resumed with bit 1 -> out_sign=1, out_abs=0.
- Ch0 at context 1, clr[0]=1 with grant and bit=0: out_sign=0, out_abs=0, context becomes 3; clr[3] without grant sets ctx3=4 only.
- rst_n low mid-stream with contexts non-midpoint: out_valid drops to 0 immediately; after release all contexts read as 4 and first grant goes to channel 0.

Source files
------------

// File: rtl/abs_share_sched_if.sv
// rtl/abs_share_sched_if.sv - request/grant and result bundle for the shared sign/abs engine
interface abs_share_sched_if #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
);
    logic [N-1:0]  req;
    logic [N-1:0]  bit_in;
    logic [N-1:0]  clr;
    logic [N-1:0]  grant;
    logic          out_valid;
    logic [CW-1:0] out_ch;
    logic          out_sign;
    logic          out_abs;

    modport master (
        output req, bit_in, clr,
        input  grant, out_valid, out_ch, out_sign, out_abs
    );

    modport slave (
        input  req, bit_in, clr,
        output grant, out_valid, out_ch, out_sign, out_abs
    );
endinterface

// File: rtl/abs_share_sched.sv
// rtl/abs_share_sched.sv - round-robin sharing of one unary sign/abs engine across N bitstreams
module abs_share_sched #(
    parameter int N   = 4,
    parameter int DEP = 3,
    parameter int CW  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    abs_share_sched_if.slave bus
);
    localparam logic [DEP-1:0] MID = DEP'(1) << (DEP - 1);
    localparam logic [DEP-1:0] MAX = '1;

    logic [DEP-1:0] ctx [N];
    logic [CW-1:0]  ptr;
    logic [N-1:0]   grant_c;
    logic [CW-1:0]  gidx;
    logic           found;
    logic [DEP-1:0] cur;
    logic [DEP-1:0] nxt;
    logic           bit_g;
    logic           sign_c;
    logic           abs_c;

    logic           valid_q;
    logic [CW-1:0]  ch_q;
    logic           sign_q;
    logic           abs_q;

    // Search begins one past the last winner so every requester is served in turn.
    always_comb begin
        grant_c = '0;
        gidx    = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!found && bus.req[j]) begin
                found      = 1'b1;
                gidx       = CW'(j);
                grant_c[j] = 1'b1;
            end
        end
    end

    // A clear on the granted channel feeds the engine the midpoint instead of the stale context.
    always_comb begin
        cur    = bus.clr[gidx] ? MID : ctx[gidx];
        bit_g  = bus.bit_in[gidx];
        sign_c = ~cur[DEP-1];
        abs_c  = bit_g ^ sign_c;
        nxt    = cur;
        if (bit_g && cur != MAX) begin
            nxt = cur + DEP'(1);
        end else if (!bit_g && cur != '0) begin
            nxt = cur - DEP'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ctx[i] <= MID;
            end
            ptr     <= CW'(N - 1);
            valid_q <= 1'b0;
            ch_q    <= '0;
            sign_q  <= 1'b0;
            abs_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.clr[i]) begin
                    ctx[i] <= MID;
                end
            end
            // Placed after the clear loop so the engine update wins on the granted channel.
            if (found) begin
                ctx[gidx] <= nxt;
                ptr       <= gidx;
                ch_q      <= gidx;
                sign_q    <= sign_c;
                abs_q     <= abs_c;
            end
            valid_q <= found;
        end
    end

    assign bus.grant     = grant_c;
    assign bus.out_valid = valid_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_sign  = sign_q;
    assign bus.out_abs   = abs_q;
endmodule

// File: tb/tb_abs_share_sched.sv
// tb/tb_abs_share_sched.sv - directed vector bench for abs_share_sched
module tb_abs_share_sched;
    localparam int N   = 4;
    localparam int DEP = 3;
    localparam int CW  = 2;

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  bit_in;
        logic [N-1:0]  clr;
        logic [N-1:0]  grant;
        logic          valid;
        logic [CW-1:0] ch;
        logic          sgn;
        logic          ab;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    abs_share_sched_if #(.N(N), .CW(CW)) bus ();

    abs_share_sched #(.N(N), .DEP(DEP), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] g, input logic v, input logic [1:0] ch,
                       input logic s, input logic a);
        vec_t t;
        t.req = r; t.bit_in = b; t.clr = c; t.grant = g;
        t.valid = v; t.ch = ch; t.sgn = s; t.ab = a;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c);
        bus.req    = r;
        bus.bit_in = b;
        bus.clr    = c;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // round robin from reset, all contexts start at 4
        add(4'hF, 4'h0, 4'h0, 4'b0001, 1, 0, 0, 0);
        add(4'hF, 4'h0, 4'h0, 4'b0010, 1, 1, 0, 0);
        add(4'hF, 4'h0, 4'h0, 4'b0100, 1, 2, 0, 0);
        add(4'hF, 4'h0, 4'h0, 4'b1000, 1, 3, 0, 0);
        add(4'hF, 4'h0, 4'h0, 4'b0001, 1, 0, 1, 1);
        // idle holds outputs; then clear everything back to 4
        add(4'h0, 4'h0, 4'h0, 4'b0000, 0, 0, 1, 1);
        add(4'h0, 4'h0, 4'hF, 4'b0000, 0, 0, 1, 1);
        // ch0 zeros: ctx 4,3,2,1,0,0
        add(4'h1, 4'h0, 4'h0, 4'b0001, 1, 0, 0, 0);
        add(4'h1, 4'h0, 4'h0, 4'b0001, 1, 0, 1, 1);
        add(4'h1, 4'h0, 4'h0, 4'b0001, 1, 0, 1, 1);
        add(4'h1, 4'h0, 4'h0, 4'b0001, 1, 0, 1, 1);
        add(4'h1, 4'h0, 4'h0, 4'b0001, 1, 0, 1, 1);
        add(4'h1, 4'h0, 4'h0, 4'b0001, 1, 0, 1, 1);
        // ch1 ones: ctx 4,5,6,7,7
        for (int i = 0; i < 5; i++) add(4'h2, 4'h2, 4'h0, 4'b0010, 1, 1, 0, 1);
        // ch2 untouched by ch0 saturation; ch0 resumes from 0
        add(4'h4, 4'h4, 4'h0, 4'b0100, 1, 2, 0, 1);
        add(4'h1, 4'h1, 4'h0, 4'b0001, 1, 0, 1, 0);
        // ch0 at 1: clear with grant, bit 0 -> from 4 to 3; clr[3] alone -> ctx3 = 4
        add(4'h1, 4'h0, 4'h9, 4'b0001, 1, 0, 0, 0);
        add(4'h1, 4'h1, 4'h0, 4'b0001, 1, 0, 1, 0);
        add(4'h8, 4'h0, 4'h0, 4'b1000, 1, 3, 0, 0);
        add(4'h8, 4'h0, 4'h0, 4'b1000, 1, 3, 1, 1);
        // ptr=3 with sparse requests: wrap to ch1 (ctx 7 stays), then ch3 (ctx 2)
        add(4'hA, 4'hF, 4'h0, 4'b0010, 1, 1, 0, 1);
        add(4'hA, 4'hF, 4'h0, 4'b1000, 1, 3, 1, 0);

        rst_n = 1'b0;
        drive(4'h0, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_ch",    32'(bus.out_ch),    32'd0);
        chk("reset_sign",  32'(bus.out_sign),  32'd0);
        chk("reset_abs",   32'(bus.out_abs),   32'd0);
        chk("reset_grant", 32'(bus.grant),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            drive(vecs[v].req, vecs[v].bit_in, vecs[v].clr);
            #1;
            chk($sformatf("v%0d_grant", v), 32'(bus.grant), 32'(vecs[v].grant));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", v), 32'(bus.out_valid), 32'(vecs[v].valid));
            chk($sformatf("v%0d_ch", v),    32'(bus.out_ch),    32'(vecs[v].ch));
            chk($sformatf("v%0d_sign", v),  32'(bus.out_sign),  32'(vecs[v].sgn));
            chk($sformatf("v%0d_abs", v),   32'(bus.out_abs),   32'(vecs[v].ab));
        end

        // asynchronous reset between edges discards the in-flight result
        @(negedge clk);
        drive(4'h1, 4'h1, 4'h0);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_sign",  32'(bus.out_sign),  32'd0);
        drive(4'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'hF, 4'h0, 4'h0);
        #1;
        chk("post_rst_first_grant", 32'(bus.grant), 32'b0001);
        drive(4'h0, 4'h0, 4'h0);

        // each context must be exactly 4: first zero gives sign 0, second gives sign 1
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                drive(4'(1 << c), 4'h0, 4'h0);
                @(posedge clk);
                #1;
                chk($sformatf("post_rst_ch%0d_ch_%0d", c, k),   32'(bus.out_ch),   32'(c));
                chk($sformatf("post_rst_ch%0d_sign_%0d", c, k), 32'(bus.out_sign), 32'(k));
            end
        end

        @(negedge clk);
        drive(4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        chk("final_idle_valid", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
